// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812/SK6812 pixel line driver.
// Default timing constants assume a 200 MHz system clock.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BIT   = 2'd1,
        ST_LATCH = 2'd2
    } ws_state_e;

    localparam int unsigned DEF_PIX_BITS = 32'd24;
    localparam int unsigned DEF_CNT_T0H  = 32'd70;
    localparam int unsigned DEF_CNT_T1H  = 32'd140;
    localparam int unsigned DEF_CNT_BIT  = 32'd250;
    localparam int unsigned DEF_CNT_RST  = 32'd10000;

    // One counter is shared by bit periods and the latch, so size it for the longer one.
    function automatic int unsigned cnt_width(input int unsigned bit_cycles,
                                              input int unsigned rst_cycles);
        int unsigned longest;
        if (bit_cycles > rst_cycles) begin
            longest = bit_cycles;
        end else begin
            longest = rst_cycles;
        end
        return $clog2(longest + 32'd1);
    endfunction

endpackage

// File: rtl/ws2812_pixel_out_if.sv
// Pixel stream handshake between the frame-buffer reader (master) and the line driver (slave).
interface ws2812_pixel_out_if
    import ws2812_pkg::*;
#(
    parameter int unsigned PIX_BITS = DEF_PIX_BITS
) ();

    logic                pix_valid_in;
    logic [PIX_BITS-1:0] pix_data_in;
    logic                pix_ready_out;
    logic                latch_in;

    modport master (
        output pix_valid_in,
        output pix_data_in,
        output latch_in,
        input  pix_ready_out
    );

    modport slave (
        input  pix_valid_in,
        input  pix_data_in,
        input  latch_in,
        output pix_ready_out
    );

endinterface

// File: rtl/ws2812_pixel_out.sv
// WS2812/SK6812 line driver: serialises whole pixels MSB-first into NRZ pulses
// and emits the latch low period on request. All outputs are registered.
module ws2812_pixel_out
    import ws2812_pkg::*;
#(
    parameter int unsigned PIX_BITS = DEF_PIX_BITS,
    parameter int unsigned CNT_T0H  = DEF_CNT_T0H,
    parameter int unsigned CNT_T1H  = DEF_CNT_T1H,
    parameter int unsigned CNT_BIT  = DEF_CNT_BIT,
    parameter int unsigned CNT_RST  = DEF_CNT_RST
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    ws2812_pixel_out_if.slave       pix,
    output logic                    busy_out,
    output logic                    ws2812_data_out
);

    localparam int unsigned CNT_W = cnt_width(CNT_BIT, CNT_RST);
    localparam int unsigned IDX_W = (PIX_BITS > 32'd1) ? $clog2(PIX_BITS) : 32'd1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CNT_BIT - 32'd1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(CNT_RST - 32'd1);
    localparam logic [CNT_W-1:0] T0H_CNT  = CNT_W'(CNT_T0H);
    localparam logic [CNT_W-1:0] T1H_CNT  = CNT_W'(CNT_T1H);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(PIX_BITS - 32'd1);

    generate
        if (!((CNT_T0H > 32'd0) && (CNT_T0H < CNT_T1H) && (CNT_T1H < CNT_BIT) &&
              (CNT_RST > 32'd0) && (PIX_BITS > 32'd0))) begin : g_bad_cfg
            $error("ws2812_pixel_out: need 0 < CNT_T0H < CNT_T1H < CNT_BIT, CNT_RST > 0, PIX_BITS > 0");
        end
    endgenerate

    ws_state_e           state_r, state_s;
    logic [PIX_BITS-1:0] shreg_r, shreg_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [CNT_W-1:0]    thr_s;
    logic                pend_r, pend_s;
    logic                ready_r, ready_s;
    logic                busy_r, busy_s;
    logic                data_r, data_s;
    logic                accept_s;

    // Next-state decode; outputs are derived from the next state so they register in step with it.
    always_comb begin
        accept_s = pix.pix_valid_in & ready_r;
        state_s  = state_r;
        shreg_s  = shreg_r;
        idx_s    = idx_r;
        cnt_s    = cnt_r;
        pend_s   = pend_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_BIT;
                    shreg_s = pix.pix_data_in;
                    idx_s   = IDX_TOP;
                    cnt_s   = CNT_ZERO;
                end else if (pend_r) begin
                    state_s = ST_LATCH;
                    cnt_s   = CNT_ZERO;
                    pend_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BIT: begin
                if (cnt_r == BIT_LAST) begin
                    if (idx_r == IDX_ZERO) begin
                        if (accept_s) begin
                            shreg_s = pix.pix_data_in;
                            idx_s   = IDX_TOP;
                            cnt_s   = CNT_ZERO;
                        end else if (pend_r) begin
                            state_s = ST_LATCH;
                            cnt_s   = CNT_ZERO;
                            pend_s  = 1'b0;
                        end else begin
                            state_s = ST_IDLE;
                            cnt_s   = CNT_ZERO;
                        end
                    end else begin
                        idx_s   = idx_r - IDX_ONE;
                        shreg_s = shreg_r << 1'b1;
                        cnt_s   = CNT_ZERO;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_LATCH: begin
                if (cnt_r == RST_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                pend_s  = 1'b0;
            end
        endcase
        // A request arriving while one is pending merges; one arriving during LATCH queues another.
        pend_s  = pend_s | pix.latch_in;
        thr_s   = shreg_s[PIX_BITS-1] ? T1H_CNT : T0H_CNT;
        data_s  = (state_s == ST_BIT) && (cnt_s < thr_s);
        busy_s  = (state_s != ST_IDLE);
        ready_s = ~pend_s & ((state_s == ST_IDLE) |
                             ((state_s == ST_BIT) & (idx_s == IDX_ZERO) & (cnt_s == BIT_LAST)));
    end

    // FSM, datapath and output registers; reset drops the line low immediately.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_IDLE;
            shreg_r <= {PIX_BITS{1'b0}};
            idx_r   <= IDX_ZERO;
            cnt_r   <= CNT_ZERO;
            pend_r  <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            data_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            pend_r  <= pend_s;
            ready_r <= ready_s;
            busy_r  <= busy_s;
            data_r  <= data_s;
        end
    end

    assign pix.pix_ready_out = ready_r;
    assign busy_out          = busy_r;
    assign ws2812_data_out   = data_r;

endmodule

// File: tb/tb_ws2812_pixel_out.sv
// Directed self-checking bench for ws2812_pixel_out with short timing
// (PIX_BITS=8, T0H=2, T1H=4, BIT=6, RST=10).
module tb_ws2812_pixel_out;

    localparam int unsigned PB = 32'd8;

    logic clk_in = 1'b0;
    logic rst_n_in;
    logic busy_out;
    logic ws2812_data_out;

    int n_vec = 0;
    int n_err = 0;

    ws2812_pixel_out_if #(.PIX_BITS(PB)) pix_if ();

    ws2812_pixel_out #(
        .PIX_BITS (PB),
        .CNT_T0H  (32'd2),
        .CNT_T1H  (32'd4),
        .CNT_BIT  (32'd6),
        .CNT_RST  (32'd10)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .pix             (pix_if),
        .busy_out        (busy_out),
        .ws2812_data_out (ws2812_data_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Entered one step after the accept edge; leaves on the last cycle of the last bit.
    task automatic measure_pixel(input string tag, input logic [7:0] word, input logic last_ready);
        for (int b = 7; b >= 0; b--) begin
            int   highs;
            logic rdy_end;
            highs   = 0;
            rdy_end = 1'b0;
            for (int c = 0; c < 6; c++) begin
                if (c > 0) tick();
                if (c == 0) expect_eq($sformatf("%s_b%0d_start", tag, b), {31'd0, ws2812_data_out}, 32'd1);
                if (ws2812_data_out === 1'b1) highs++;
                if (c == 5) rdy_end = pix_if.pix_ready_out;
            end
            expect_eq($sformatf("%s_b%0d_highs", tag, b), highs, word[b] ? 32'd4 : 32'd2);
            expect_eq($sformatf("%s_b%0d_ready", tag, b), {31'd0, rdy_end},
                      (b == 0) ? {31'd0, last_ready} : 32'd0);
            if (b > 0) tick();
        end
    endtask

    // Entered on the first LATCH cycle; counts busy cycles, bounded.
    task automatic count_latch(output int n, output int hi, output int rdy);
        n   = 0;
        hi  = 0;
        rdy = 0;
        while ((busy_out === 1'b1) && (n < 40)) begin
            n++;
            if (ws2812_data_out !== 1'b0) hi++;
            if (pix_if.pix_ready_out !== 1'b0) rdy++;
            tick();
        end
    endtask

    initial begin
        int n, hi, rdy;
        rst_n_in             = 1'b0;
        pix_if.pix_valid_in  = 1'b0;
        pix_if.pix_data_in   = 8'h00;
        pix_if.latch_in      = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        expect_eq("rst_ready", {31'd0, pix_if.pix_ready_out}, 32'd1);
        expect_eq("rst_busy",  {31'd0, busy_out},             32'd0);
        expect_eq("rst_data",  {31'd0, ws2812_data_out},      32'd0);
        rst_n_in = 1'b1;
        tick();
        tick();

        // 1: single pixel A5
        pix_if.pix_valid_in = 1'b1;
        pix_if.pix_data_in  = 8'hA5;
        tick();
        pix_if.pix_valid_in = 1'b0;
        measure_pixel("t1", 8'hA5, 1'b1);
        tick();
        expect_eq("t1_idle_busy",  {31'd0, busy_out},             32'd0);
        expect_eq("t1_idle_data",  {31'd0, ws2812_data_out},      32'd0);
        expect_eq("t1_idle_ready", {31'd0, pix_if.pix_ready_out}, 32'd1);

        // 2: valid held, FF then 00 back-to-back
        pix_if.pix_valid_in = 1'b1;
        pix_if.pix_data_in  = 8'hFF;
        tick();
        pix_if.pix_data_in  = 8'h00;
        measure_pixel("t2a", 8'hFF, 1'b1);
        tick();
        pix_if.pix_valid_in = 1'b0;
        expect_eq("t2_no_gap_busy", {31'd0, busy_out}, 32'd1);
        measure_pixel("t2b", 8'h00, 1'b1);
        tick();
        expect_eq("t2_idle_busy", {31'd0, busy_out}, 32'd0);

        // 3: latch with no pixels
        pix_if.latch_in = 1'b1;
        tick();
        pix_if.latch_in = 1'b0;
        expect_eq("t3_pend_ready", {31'd0, pix_if.pix_ready_out}, 32'd0);
        expect_eq("t3_pend_busy",  {31'd0, busy_out},             32'd0);
        tick();
        count_latch(n, hi, rdy);
        expect_eq("t3_latch_len",   n,   32'd10);
        expect_eq("t3_latch_high",  hi,  32'd0);
        expect_eq("t3_latch_ready", rdy, 32'd0);
        expect_eq("t3_after_ready", {31'd0, pix_if.pix_ready_out}, 32'd1);

        // 4: latch together with accept of 80
        pix_if.pix_valid_in = 1'b1;
        pix_if.pix_data_in  = 8'h80;
        pix_if.latch_in     = 1'b1;
        tick();
        pix_if.pix_valid_in = 1'b0;
        pix_if.latch_in     = 1'b0;
        measure_pixel("t4", 8'h80, 1'b0);
        tick();
        count_latch(n, hi, rdy);
        expect_eq("t4_latch_len",   n,   32'd10);
        expect_eq("t4_latch_high",  hi,  32'd0);
        expect_eq("t4_latch_ready", rdy, 32'd0);
        expect_eq("t4_after_ready", {31'd0, pix_if.pix_ready_out}, 32'd1);

        // 5: reset mid-pixel, then a clean pixel
        pix_if.pix_valid_in = 1'b1;
        pix_if.pix_data_in  = 8'hA5;
        tick();
        pix_if.pix_valid_in = 1'b0;
        repeat (19) tick();
        expect_eq("t5_pre_rst_data", {31'd0, ws2812_data_out}, 32'd1);
        expect_eq("t5_pre_rst_busy", {31'd0, busy_out},        32'd1);
        #1;
        rst_n_in = 1'b0;
        #1;
        expect_eq("t5_rst_data",  {31'd0, ws2812_data_out},      32'd0);
        expect_eq("t5_rst_ready", {31'd0, pix_if.pix_ready_out}, 32'd1);
        expect_eq("t5_rst_busy",  {31'd0, busy_out},             32'd0);
        #4;
        rst_n_in = 1'b1;
        tick();
        pix_if.pix_valid_in = 1'b1;
        pix_if.pix_data_in  = 8'h3C;
        tick();
        pix_if.pix_valid_in = 1'b0;
        measure_pixel("t5", 8'h3C, 1'b1);
        tick();
        expect_eq("t5_idle_busy", {31'd0, busy_out}, 32'd0);

        // 6: two latch pulses during one pixel -> one latch
        pix_if.pix_valid_in = 1'b1;
        pix_if.pix_data_in  = 8'hC3;
        tick();
        pix_if.pix_valid_in = 1'b0;
        repeat (2) tick();
        pix_if.latch_in = 1'b1;
        tick();
        pix_if.latch_in = 1'b0;
        repeat (10) tick();
        pix_if.latch_in = 1'b1;
        tick();
        pix_if.latch_in = 1'b0;
        repeat (33) tick();
        expect_eq("t6_last_busy",  {31'd0, busy_out},             32'd1);
        expect_eq("t6_last_ready", {31'd0, pix_if.pix_ready_out}, 32'd0);
        tick();
        count_latch(n, hi, rdy);
        expect_eq("t6_latch_len",  n,  32'd10);
        expect_eq("t6_latch_high", hi, 32'd0);
        repeat (5) tick();
        expect_eq("t6_single_latch", {31'd0, busy_out},             32'd0);
        expect_eq("t6_end_ready",    {31'd0, pix_if.pix_ready_out}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
